dmem_rv32: RTL
==============

# dmem_rv32

Byte-addressed RV32 data memory with a valid/ready request/response handshake, sub-word load/store, and misaligned/out-of-range error reporting. It is the next generation of the flat word-array memory. It adds byte/halfword/word access with sign or zero extension, a registered read, and backpressure. An optional post-reset clear sequencer zeroes the contents. It sits between the core's load/store unit and the data store.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two, minimum 4.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_wdata  in  32  store data, right-aligned: bits [7:0] for a byte, [15:0] for a half.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_error  out  1  access was misaligned, out of range, or used an illegal size.

## Operation
- States:
  - CLEAR: zeroing words 0..DEPTH-1; req_ready = 0.
  - IDLE: no response pending; req_ready = 1.
  - RESP: a response is held.
- Reset values:
  - State enters CLEAR (or IDLE when the clear feature is compiled out).
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, clear counter = 0.
- Accept: a request is accepted when req_valid && req_ready. req_ready = (state==IDLE) || (state==RESP && rsp_ready).
- Decode of an accepted request:
  - word index = req_addr[ADDR_WIDTH-1:2].
  - lane = req_addr[1:0].
- Error conditions (rsp_error = 1):
  - size 01 with lane[0] = 1.
  - size 10 with lane != 0.
  - size 11.
  - word index >= DEPTH.
  - On error: no write occurs and rsp_rdata = 0.
- Store:
  - Only the addressed byte lanes are written; the other lanes keep their value.
  - Byte writes lane = req_wdata[7:0].
  - Half writes lanes lane..lane+1 = req_wdata[15:0].
  - Word writes all 4 lanes.
  - The write commits at the accepting edge. The response carries rdata = 0, error = 0.
- Load:
  - The word is read at the accepting edge.
  - The selected lane(s) are shifted down and extended per req_unsigned, then registered into rsp_rdata.
  - A word load ignores req_unsigned.
- Response transitions:
  - The response is held stable until rsp_valid && rsp_ready.
  - On that handshake with no new accept: go to IDLE and clear rsp_valid.
  - On a simultaneous new accept: stay in RESP and load the new response.
- CLEAR:
  - Writes 0 to word[counter] each cycle and increments the counter.
  - After word DEPTH-1, go to IDLE.
  - Takes DEPTH cycles after rst deasserts.

## Timing
- Load latency: accept at edge N, then rsp_valid = 1 and data valid after edge N, visible in cycle N+1.
- Throughput: 1 request/cycle while rsp_ready is held high.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data. No forwarding is needed because the write commits at the accept edge.
- Backpressure: with rsp_ready = 0 in RESP, req_ready = 0. No request is lost and rsp_* do not change.
- rst asserted at any time, including mid-CLEAR or in RESP:
  - Outputs return to their reset values immediately (asynchronous).
  - The held response is dropped.
  - The clear sequence restarts from word 0.
  - Memory contents are not reset directly; only the CLEAR sequence zeroes them.
- Decode and error checks are combinational on req_*; outputs are registered only.

## Configuration
- DMEM_CLEAR_EN defined:
  - The CLEAR state exists.
  - After every reset the memory reads all zeros once the state reaches IDLE.
  - req_ready stays low for DEPTH cycles after rst deasserts.
- DMEM_CLEAR_EN undefined:
  - No CLEAR state and no clear counter; reset goes directly to IDLE.
  - req_ready = 1 in the first cycle after rst deasserts.
  - Memory contents after reset are undefined (X in simulation).

## Test plan
- Clear: with DMEM_CLEAR_EN and DEPTH = 64, deassert rst -> req_ready is low for exactly 64 cycles. After that, a word load at 0x00 and at 0xFC returns 0x00000000 with error 0.
- Sub-word store/load:
  - Store word 0x11223344 at 0x10, then store byte 0xAB at 0x12 -> word load at 0x10 returns 0x11AB3344.
  - Signed byte load at 0x12 -> 0xFFFFFFAB.
  - Unsigned byte load at 0x12 -> 0x000000AB.
- Half loads: store 0x8001 as a half at 0x22 -> signed half load at 0x22 returns 0xFFFF8001; unsigned half load returns 0x00008001.
- Errors:
  - Word load at 0x06 -> rsp_error = 1, rdata = 0.
  - Half store at 0x21 -> error 1, and word 0x20 is unchanged.
  - Word load at 0x100 with DEPTH = 64 -> error 1.
  - req_size = 11 -> error 1.
- Backpressure/throughput:
  - Hold rsp_ready = 0 for 5 cycles with req_valid = 1 -> only one accept happens and rsp_rdata is stable.
  - Then raise rsp_ready and issue 4 back-to-back loads -> 4 responses arrive on consecutive cycles, in order.
- Reset mid-operation: assert rst while in RESP with rsp_valid = 1, and again at clear counter = 20 -> rsp_valid drops immediately. Clear restarts and lasts a full DEPTH cycles after rst deasserts.

Source files
------------

// File: rtl/dmem_rv32.sv
// Byte-addressed RV32 data memory: valid/ready request/response, sub-word access, error reporting.
// Optional post-reset zeroing sequencer enabled by defining DMEM_CLEAR_EN.
module dmem_rv32 #(
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_error
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

`ifdef DMEM_CLEAR_EN
   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RESP} state_t;
   localparam state_t RST_STATE = S_CLEAR;
   logic [IDX_W-1:0] r_clr_cnt;
`else
   typedef enum logic {S_IDLE, S_RESP} state_t;
   localparam state_t RST_STATE = S_IDLE;
`endif

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_mem [DEPTH];

   logic [IDX_W-1:0] w_widx;
   logic [1:0]       w_lane;
   logic             w_oor;
   logic             w_err;
   logic             w_accept;
   logic             w_we;
   logic [3:0]       w_be;
   logic [31:0]      w_wrep;
   logic [31:0]      w_shift;
   logic [31:0]      w_ldata;

   assign w_widx   = req_addr[IDX_W+1:2];
   assign w_lane   = req_addr[1:0];
   // Any set bit above the index field means word index >= DEPTH.
   assign w_oor    = |req_addr[ADDR_WIDTH-1:IDX_W+2];
   assign w_err    = (req_size == 2'b11)
                   | ((req_size == 2'b01) & w_lane[0])
                   | ((req_size == 2'b10) & (w_lane != 2'b00))
                   | w_oor;
   assign w_accept = req_valid & req_ready;
   assign w_we     = w_accept & req_write & ~w_err;

   always_comb begin
      w_be   = 4'b1111;
      w_wrep = req_wdata;
      unique case (req_size)
         2'b00: begin
            w_be   = 4'b0001 << w_lane;
            w_wrep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be   = 4'b0011 << w_lane;
            w_wrep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_shift = r_mem[w_widx] >> {w_lane, 3'b000};

   always_comb begin
      w_ldata = w_shift;
      unique case (req_size)
         2'b00: w_ldata = req_unsigned ? {24'h000000, w_shift[7:0]}
                                       : {{24{w_shift[7]}}, w_shift[7:0]};
         2'b01: w_ldata = req_unsigned ? {16'h0000, w_shift[15:0]}
                                       : {{16{w_shift[15]}}, w_shift[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      unique case (r_state)
`ifdef DMEM_CLEAR_EN
         S_CLEAR: if (r_clr_cnt == IDX_W'(DEPTH-1)) w_next = S_IDLE;
`endif
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = S_RESP;
         end
         S_RESP: begin
            req_ready = rsp_ready;
            if (rsp_ready && !req_valid) w_next = S_IDLE;
         end
         default: w_next = RST_STATE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RST_STATE;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
`ifdef DMEM_CLEAR_EN
         r_clr_cnt <= '0;
`endif
      end else begin
         r_state <= w_next;
`ifdef DMEM_CLEAR_EN
         if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
`endif
         if (w_accept) begin
            rsp_valid <= 1'b1;
            rsp_error <= w_err;
            rsp_rdata <= (w_err || req_write) ? '0 : w_ldata;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   // Storage has no reset; only the clear sequence zeroes it.
   always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
      if (r_state == S_CLEAR) begin
         r_mem[r_clr_cnt] <= '0;
      end else
`endif
      if (w_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wrep[8*i +: 8];
         end
      end
   end

endmodule
